time_score_regs: RTL and testbench
==================================

Name: time_score_regs

Overview:
- Avalon-MM slave holding the match clock and per-player scores for the Time-Score SoC.
- Next generation of the score register block:
  - Built-in one-second prescaler and a minute/second counter that can count up or down.
  - Parametrised number of score channels.
  - Byte-enable writes.
  - Sticky expiry status with an interrupt.
- Sits on the HPS/Nios lightweight bus. The display driver and the CPU read it; the CPU configures it.

Parameters:
- CLK_FREQ_HZ, 50000000: reset value of TICK_DIV, in clock cycles per second.
- NUM_SCORES, 4: number of score registers, 1..11.
- SCORE_W, 16: score register width, 1..32. Reads are zero-extended to 32 bits.
- MAX_MINUTE, 99: highest minute value. Writes are clamped to it, and up-count wraps past it.

Ports:
- iClk  in  1  system clock.
- iReset_n  in  1  asynchronous active-low reset.
- iChipSelect  in  1  slave select.
- iWrite  in  1  write strobe, qualified by iChipSelect.
- iRead  in  1  read strobe, qualified by iChipSelect.
- iAddr  in  4  word address.
- iByteEnable  in  4  byte lanes for writes.
- iData  in  32  write data.
- oData  out  32  registered read data.
- oIrq  out  1  level interrupt.

Behaviour:
- Reset and clocking:
  - One clock, iClk. Reset is asynchronous, active-low, on iReset_n.
  - All registers, oData and oIrq reset to 0, except TICK_DIV, which resets to CLK_FREQ_HZ.
- Address map:
  - 0 CTRL: [0] RUN, [1] DOWN, [2] IRQ_EN, [3] CLEAR. CLEAR is write-one, self-clearing and reads 0.
  - 1 STATUS: [0] EXPIRED, sticky, write-1-to-clear. [1] RUNNING, read-only, mirrors RUN.
  - 2 MINUTE.
  - 3 SECOND.
  - 4 TICK_DIV.
  - 5..4+NUM_SCORES: SCORE[i].
  - Unmapped addresses read 0 and ignore writes.
- Bus writes:
  - Write occurs when iChipSelect & iWrite. Only lanes with iByteEnable set are updated.
  - MINUTE, SECOND and SCORE are lane-merged, then truncated to register width.
- Bus reads:
  - Read occurs when iChipSelect & iRead & ~iWrite.
  - oData is loaded on that edge, so read latency is one cycle.
  - oData holds its value on all other cycles.
  - If iWrite and iRead are both asserted, the write is performed and oData holds.
- Clamping:
  - A value written to SECOND that is above 59 stores 59.
  - A value written to MINUTE that is above MAX_MINUTE stores MAX_MINUTE.
- Prescaler:
  - Counts 0..TICK_DIV-1 while RUN=1, then emits a one-cycle tick and restarts at 0.
  - Freezes while RUN=0.
  - Resets to 0 on any write to MINUTE, SECOND, TICK_DIV, or on CLEAR.
  - TICK_DIV of 0 or 1 produces a tick every cycle.
- Up mode (DOWN=0), on tick:
  - second = second+1.
  - At 59, second becomes 0 and minute increments.
  - minute wraps from MAX_MINUTE to 0.
- Down mode (DOWN=1), on tick:
  - If minute=0 and second=0: set EXPIRED, clear RUN, leave the counters unchanged.
  - Else if second=0: second becomes 59 and minute decrements.
  - Else second decrements.
- Priority in a single cycle:
  - A CPU write to MINUTE or SECOND wins over a tick in the same cycle; the tick is discarded.
  - CLEAR zeroes MINUTE, SECOND, all SCOREs and the prescaler. CLEAR does not touch TICK_DIV or EXPIRED.
  - A CTRL write carrying CLEAR=1 also updates RUN, DOWN and IRQ_EN from the same data.
  - If an expiry set and a W1C clear of EXPIRED land in the same cycle, the set wins.
- Interrupt:
  - oIrq is registered: it equals EXPIRED & IRQ_EN, one cycle after either changes.
- Reset mid-count: all state returns to reset values immediately, with no pending tick retained.

Decomposition:
- Shared package time_score_pkg:
  - Address constants ADDR_CTRL, ADDR_STATUS, ADDR_MINUTE, ADDR_SECOND, ADDR_TICK_DIV, ADDR_SCORE0.
  - CTRL and STATUS bit indices.
  - MAX_SECOND = 59.
- Sub-module time_score_counter:
  - Contains the prescaler and the min/sec up/down counter.
  - Inputs: run, down, load strobes and values, clear.
  - Outputs: minute, second, expire pulse.
- The top level keeps bus decode, CTRL/STATUS, the SCORE array and read mux.

Test Plan:
- Reset -> all reads return 0, except TICK_DIV, which reads 50000000. oIrq=0.
- Write SECOND=58, TICK_DIV=4 (use 4 for simulation), CTRL=0x1 -> after 8 cycles, MINUTE=1, SECOND=0.
- Write MINUTE=0, SECOND=1, CTRL=0x7 -> after 4 cycles, SECOND=0. Next tick sets STATUS=0x1 (EXPIRED=1, RUN cleared). oIrq=1 one cycle later.
- Write STATUS=0x1 -> EXPIRED=0 and oIrq=0 on the following cycle.
- With SCORE0=0x1234, write 0xABCD with iByteEnable=4'b0010 -> SCORE0 reads 0xAB34.
- Write SECOND=75 in the same cycle as a tick -> SECOND reads 59 and the prescaler restarts at 0.
- Read addr 15 -> oData=0 on the next cycle.

Source files
------------

// File: rtl/time_score_pkg.sv
// Shared address map, register bit positions and helpers for the Time-Score
// match clock / score register block.
package time_score_pkg;

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_STATUS   = 4'd1;
    localparam logic [3:0] ADDR_MINUTE   = 4'd2;
    localparam logic [3:0] ADDR_SECOND   = 4'd3;
    localparam logic [3:0] ADDR_TICK_DIV = 4'd4;
    localparam logic [3:0] ADDR_SCORE0   = 4'd5;

    localparam int unsigned CTRL_RUN    = 0;
    localparam int unsigned CTRL_DOWN   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_CLEAR  = 3;

    localparam int unsigned STAT_EXPIRED = 0;
    localparam int unsigned STAT_RUNNING = 1;

    localparam int unsigned MAX_SECOND = 59;
    localparam int unsigned SEC_W      = 6;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } count_dir_e;

    // Replace only the byte lanes selected by be; other lanes keep cur.
    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] wr,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wr[8*i +: 8];
        end
        return res;
    endfunction

    function automatic int unsigned min_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/time_score_counter.sv
// One-second prescaler feeding a minute/second counter that counts up with
// wrap or down to 0:00, flagging expiry with a single-cycle pulse.
module time_score_counter
    import time_score_pkg::*;
#(
    parameter int unsigned MAX_MINUTE = 99,
    parameter int unsigned MIN_W      = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  count_dir_e        dir,
    input  logic [31:0]       tick_div,
    input  logic              min_load,
    input  logic [MIN_W-1:0]  min_val,
    input  logic              sec_load,
    input  logic [SEC_W-1:0]  sec_val,
    input  logic              presc_restart,
    input  logic              clear,
    output logic [MIN_W-1:0]  minute,
    output logic [SEC_W-1:0]  second,
    output logic              expire
);

    logic [31:0]      presc_q, presc_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             tick;

    always_comb begin
        presc_d = presc_q;
        min_d   = min_q;
        sec_d   = sec_q;
        expire  = 1'b0;
        // Terminal count at TICK_DIV-1; a divider of 0 or 1 ticks every cycle.
        tick    = run && (({1'b0, presc_q} + 33'd1) >= {1'b0, tick_div});

        if (run) presc_d = tick ? '0 : presc_q + 32'd1;
        if (clear || min_load || sec_load || presc_restart) presc_d = '0;

        if (clear) begin
            min_d = '0;
            sec_d = '0;
        end else if (min_load || sec_load) begin
            if (min_load) min_d = min_val;
            if (sec_load) sec_d = sec_val;
        end else if (tick) begin
            if (dir == DIR_DOWN) begin
                if (min_q == '0 && sec_q == '0) begin
                    expire = 1'b1;
                end else if (sec_q == '0) begin
                    sec_d = SEC_W'(MAX_SECOND);
                    min_d = min_q - MIN_W'(1);
                end else begin
                    sec_d = sec_q - SEC_W'(1);
                end
            end else begin
                if (sec_q == SEC_W'(MAX_SECOND)) begin
                    sec_d = '0;
                    min_d = (min_q == MIN_W'(MAX_MINUTE)) ? '0 : min_q + MIN_W'(1);
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            min_q   <= '0;
            sec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
        end
    end

    assign minute = min_q;
    assign second = sec_q;

endmodule

// File: rtl/time_score_regs.sv
// Avalon-MM register block: match clock control/status, tick divider and the
// per-player score array, with registered read data and expiry interrupt.
module time_score_regs
    import time_score_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned NUM_SCORES  = 4,
    parameter int unsigned SCORE_W     = 16,
    parameter int unsigned MAX_MINUTE  = 99
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iChipSelect,
    input  logic        iWrite,
    input  logic        iRead,
    input  logic [3:0]  iAddr,
    input  logic [3:0]  iByteEnable,
    input  logic [31:0] iData,
    output logic [31:0] oData,
    output logic        oIrq
);

    localparam int unsigned MIN_W = min_width(MAX_MINUTE);

    logic               wr_en, rd_en;
    logic               wr_ctrl, wr_status, wr_minute, wr_second, wr_tick_div;
    logic               clear;
    logic [31:0]        min_merged, sec_merged;
    logic [MIN_W-1:0]   min_load_val;
    logic [SEC_W-1:0]   sec_load_val;

    logic               run_q, run_d;
    logic               down_q, down_d;
    logic               irq_en_q, irq_en_d;
    logic               expired_q, expired_d;
    logic               irq_q, irq_d;
    logic [31:0]        tick_div_q, tick_div_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic [31:0]        rd_mux;
    logic [SCORE_W-1:0] score_q [NUM_SCORES];
    logic [SCORE_W-1:0] score_d [NUM_SCORES];

    logic [MIN_W-1:0]   minute;
    logic [SEC_W-1:0]   second;
    logic               expire;

    always_comb begin
        wr_en       = iChipSelect & iWrite;
        rd_en       = iChipSelect & iRead & ~iWrite;
        // CTRL and STATUS bits all live in byte lane 0.
        wr_ctrl     = wr_en && (iAddr == ADDR_CTRL) && iByteEnable[0];
        wr_status   = wr_en && (iAddr == ADDR_STATUS) && iByteEnable[0];
        wr_minute   = wr_en && (iAddr == ADDR_MINUTE);
        wr_second   = wr_en && (iAddr == ADDR_SECOND);
        wr_tick_div = wr_en && (iAddr == ADDR_TICK_DIV);
        clear       = wr_ctrl && iData[CTRL_CLEAR];

        // Clamp on the full merged word so out-of-range writes saturate.
        min_merged   = lane_merge(32'(minute), iData, iByteEnable);
        sec_merged   = lane_merge(32'(second), iData, iByteEnable);
        min_load_val = (min_merged > MAX_MINUTE) ? MIN_W'(MAX_MINUTE) : min_merged[MIN_W-1:0];
        sec_load_val = (sec_merged > MAX_SECOND) ? SEC_W'(MAX_SECOND) : sec_merged[SEC_W-1:0];
    end

    time_score_counter #(
        .MAX_MINUTE (MAX_MINUTE),
        .MIN_W      (MIN_W)
    ) u_counter (
        .clk           (iClk),
        .rst_n         (iReset_n),
        .run           (run_q),
        .dir           (down_q ? DIR_DOWN : DIR_UP),
        .tick_div      (tick_div_q),
        .min_load      (wr_minute),
        .min_val       (min_load_val),
        .sec_load      (wr_second),
        .sec_val       (sec_load_val),
        .presc_restart (wr_tick_div),
        .clear         (clear),
        .minute        (minute),
        .second        (second),
        .expire        (expire)
    );

    always_comb begin
        run_d      = run_q;
        down_d     = down_q;
        irq_en_d   = irq_en_q;
        expired_d  = expired_q;
        irq_d      = expired_q & irq_en_q;
        tick_div_d = tick_div_q;

        if (expire) run_d = 1'b0;
        if (wr_ctrl) begin
            run_d    = iData[CTRL_RUN];
            down_d   = iData[CTRL_DOWN];
            irq_en_d = iData[CTRL_IRQ_EN];
        end

        if (wr_status && iData[STAT_EXPIRED]) expired_d = 1'b0;
        if (expire) expired_d = 1'b1;

        if (wr_tick_div) tick_div_d = lane_merge(tick_div_q, iData, iByteEnable);

        for (int unsigned i = 0; i < NUM_SCORES; i++) begin
            score_d[i] = score_q[i];
            if (clear) begin
                score_d[i] = '0;
            end else if (wr_en && (iAddr == 4'(ADDR_SCORE0 + i))) begin
                score_d[i] = SCORE_W'(lane_merge(32'(score_q[i]), iData, iByteEnable));
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (iAddr)
            ADDR_CTRL: begin
                rd_mux[CTRL_RUN]    = run_q;
                rd_mux[CTRL_DOWN]   = down_q;
                rd_mux[CTRL_IRQ_EN] = irq_en_q;
            end
            ADDR_STATUS: begin
                rd_mux[STAT_EXPIRED] = expired_q;
                rd_mux[STAT_RUNNING] = run_q;
            end
            ADDR_MINUTE:   rd_mux = 32'(minute);
            ADDR_SECOND:   rd_mux = 32'(second);
            ADDR_TICK_DIV: rd_mux = tick_div_q;
            default: begin
                for (int unsigned i = 0; i < NUM_SCORES; i++) begin
                    if (iAddr == 4'(ADDR_SCORE0 + i)) rd_mux = 32'(score_q[i]);
                end
            end
        endcase
        rd_data_d = rd_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            run_q      <= 1'b0;
            down_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            expired_q  <= 1'b0;
            irq_q      <= 1'b0;
            tick_div_q <= 32'(CLK_FREQ_HZ);
            rd_data_q  <= '0;
            for (int unsigned i = 0; i < NUM_SCORES; i++) score_q[i] <= '0;
        end else begin
            run_q      <= run_d;
            down_q     <= down_d;
            irq_en_q   <= irq_en_d;
            expired_q  <= expired_d;
            irq_q      <= irq_d;
            tick_div_q <= tick_div_d;
            rd_data_q  <= rd_data_d;
            for (int unsigned i = 0; i < NUM_SCORES; i++) score_q[i] <= score_d[i];
        end
    end

    assign oData = rd_data_q;
    assign oIrq  = irq_q;

endmodule

// File: tb/tb_time_score_regs.sv
// Directed bench for time_score_regs with a total-seconds behavioural model.
module tb_time_score_regs;

    localparam int unsigned NS   = 4;
    localparam int unsigned SW   = 16;
    localparam int unsigned MAXM = 99;
    localparam int unsigned CF   = 50000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs, wr, rd;
    logic [3:0]  addr, be;
    logic [31:0] wdata;
    logic [31:0] odata;
    logic        irq;

    always #5 clk = ~clk;

    time_score_regs #(
        .CLK_FREQ_HZ (CF),
        .NUM_SCORES  (NS),
        .SCORE_W     (SW),
        .MAX_MINUTE  (MAXM)
    ) dut (
        .iClk        (clk),
        .iReset_n    (rst_n),
        .iChipSelect (cs),
        .iWrite      (wr),
        .iRead       (rd),
        .iAddr       (addr),
        .iByteEnable (be),
        .iData       (wdata),
        .oData       (odata),
        .oIrq        (irq)
    );

    // Model: clock kept as total seconds, prescaler as a plain count.
    int unsigned m_time, m_presc, m_div;
    bit          m_run, m_down, m_irqen, m_exp, m_irq;
    logic [31:0] m_odata;
    logic [31:0] m_score [NS];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] mask;
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] rdval(input logic [3:0] a);
        int idx;
        idx = int'(a) - 5;
        case (a)
            4'd0: return {29'b0, m_irqen, m_down, m_run};
            4'd1: return {30'b0, m_run, m_exp};
            4'd2: return m_time / 60;
            4'd3: return m_time % 60;
            4'd4: return m_div;
            default: return (idx >= 0 && idx < int'(NS)) ? m_score[idx] : 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_time = 0; m_presc = 0; m_div = CF;
        m_run = 0; m_down = 0; m_irqen = 0; m_exp = 0; m_irq = 0;
        m_odata = '0;
        for (int i = 0; i < int'(NS); i++) m_score[i] = '0;
    endtask

    task automatic model_step(input logic c, input logic w_i, input logic r_i,
                              input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        bit w, r, tick, expire, hold, irq_next;
        int unsigned t, p;
        logic [31:0] mv;
        int idx;
        w = c && w_i;
        r = c && r_i && !w_i;
        if (r) m_odata = rdval(a);
        irq_next = m_exp && m_irqen;
        tick = m_run && (m_div <= 1 || m_presc == m_div - 1);
        hold = w && (a == 4'd2 || a == 4'd3 || (a == 4'd0 && b[0] && d[3]));
        t = m_time; p = m_presc; expire = 0;
        if (m_run) p = tick ? 0 : m_presc + 1;
        if (tick && !hold) begin
            if (m_down) begin
                if (m_time == 0) expire = 1;
                else t = m_time - 1;
            end else begin
                t = (m_time + 1) % ((MAXM + 1) * 60);
            end
        end
        if (expire) m_run = 0;
        if (w && a == 4'd1 && b[0] && d[0]) m_exp = 0;
        if (w) begin
            idx = int'(a) - 5;
            case (a)
                4'd0: if (b[0]) begin
                    m_run = d[0]; m_down = d[1]; m_irqen = d[2];
                    if (d[3]) begin
                        t = 0; p = 0;
                        for (int i = 0; i < int'(NS); i++) m_score[i] = '0;
                    end
                end
                4'd2: begin
                    mv = merge(m_time / 60, d, b);
                    if (mv > MAXM) mv = MAXM;
                    t = mv * 60 + m_time % 60; p = 0;
                end
                4'd3: begin
                    mv = merge(m_time % 60, d, b);
                    if (mv > 59) mv = 59;
                    t = (m_time / 60) * 60 + mv; p = 0;
                end
                4'd4: begin
                    m_div = merge(m_div, d, b); p = 0;
                end
                default: if (idx >= 0 && idx < int'(NS))
                    m_score[idx] = merge(m_score[idx], d, b) & 32'h0000_FFFF;
            endcase
        end
        if (expire) m_exp = 1;
        m_time = t; m_presc = p; m_irq = irq_next;
    endtask

    // One bus cycle: drive at negedge, advance model, compare at next negedge.
    task automatic cyc(input logic c, input logic w_i, input logic r_i,
                       input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        cs = c; wr = w_i; rd = r_i; addr = a; be = b; wdata = d;
        if (rst_n) model_step(c, w_i, r_i, a, b, d);
        @(negedge clk);
        check("odata_model", odata, m_odata);
        check("irq_model", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic wrw(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, 1'b0, a, 4'hF, d);
    endtask

    task automatic wrb(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        cyc(1'b1, 1'b1, 1'b0, a, b, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 4'd3, 4'h0, 32'd0);
    endtask

    task automatic rd_lit(input string name, input logic [3:0] a, input logic [31:0] exp);
        cyc(1'b1, 1'b0, 1'b1, a, 4'h0, 32'd0);
        check(name, odata, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cs = 0; wr = 0; rd = 0; addr = '0; be = '0; wdata = '0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("odata_reset", odata, 32'd0);
            check("irq_reset", {31'b0, irq}, 32'd0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        rd_lit("tick_div_reset", 4'd4, 32'd50000000);
        rd_lit("ctrl_reset", 4'd0, 32'd0);
        rd_lit("status_reset", 4'd1, 32'd0);
        rd_lit("score0_reset", 4'd5, 32'd0);

        // Up count across a minute boundary.
        wrw(4'd3, 32'd58);
        wrw(4'd4, 32'd4);
        wrw(4'd0, 32'h1);
        idle(8);
        rd_lit("minute_rollover", 4'd2, 32'd1);
        rd_lit("second_rollover", 4'd3, 32'd0);

        // Down count to expiry with interrupt.
        wrw(4'd0, 32'h0);
        wrw(4'd2, 32'd0);
        wrw(4'd3, 32'd1);
        wrw(4'd0, 32'h7);
        idle(4);
        rd_lit("second_down_zero", 4'd3, 32'd0);
        idle(3);
        rd_lit("status_expired", 4'd1, 32'h1);
        check("irq_set", {31'b0, irq}, 32'd1);

        wrw(4'd1, 32'h1);
        idle(1);
        check("irq_cleared", {31'b0, irq}, 32'd0);
        rd_lit("status_w1c", 4'd1, 32'h0);

        // Byte-lane merges and truncation to SCORE_W.
        wrw(4'd5, 32'h1234);
        wrb(4'd5, 32'hABCD, 4'b0010);
        rd_lit("score0_lane1", 4'd5, 32'hAB34);
        wrb(4'd8, 32'hDEADBEEF, 4'b1100);
        rd_lit("score3_upper_lanes", 4'd8, 32'h0);
        wrw(4'd6, 32'h12345678);
        rd_lit("score1_trunc", 4'd6, 32'h5678);

        // SECOND write on the tick cycle: clamps, tick discarded.
        wrw(4'd4, 32'd4);
        wrw(4'd0, 32'h1);
        idle(3);
        wrw(4'd3, 32'd75);
        rd_lit("second_clamp", 4'd3, 32'd59);
        idle(2);
        rd_lit("second_before_tick", 4'd3, 32'd59);
        rd_lit("second_after_tick", 4'd3, 32'd0);
        wrw(4'd0, 32'h0);

        // MINUTE write mid-period restarts the prescaler.
        wrw(4'd3, 32'd10);
        wrw(4'd0, 32'h1);
        idle(1);
        wrw(4'd2, 32'd5);
        idle(2);
        rd_lit("presc_restart_hold", 4'd3, 32'd10);
        idle(1);
        rd_lit("presc_restart_tick", 4'd3, 32'd11);
        wrw(4'd0, 32'h0);

        // Minute clamp and MAX_MINUTE wrap with TICK_DIV=0.
        wrw(4'd4, 32'd0);
        wrw(4'd2, 32'd200);
        rd_lit("minute_clamp", 4'd2, 32'd99);
        wrw(4'd3, 32'd59);
        wrw(4'd0, 32'h1);
        wrw(4'd0, 32'h0);
        rd_lit("minute_wrap", 4'd2, 32'd0);
        rd_lit("second_wrap", 4'd3, 32'd0);

        // Down borrow.
        wrw(4'd2, 32'd2);
        wrw(4'd3, 32'd0);
        wrw(4'd0, 32'h3);
        wrw(4'd0, 32'h0);
        rd_lit("minute_borrow", 4'd2, 32'd1);
        rd_lit("second_borrow", 4'd3, 32'd59);

        // CLEAR together with RUN.
        wrw(4'd0, 32'h9);
        rd_lit("ctrl_clear_reads0", 4'd0, 32'h1);
        rd_lit("score0_cleared", 4'd5, 32'h0);
        rd_lit("tick_div_kept", 4'd4, 32'd0);
        wrw(4'd0, 32'h0);

        // Simultaneous read+write, unmapped space, empty byte enable.
        cyc(1'b1, 1'b1, 1'b1, 4'd7, 4'hF, 32'h55);
        rd_lit("score2_rw", 4'd7, 32'h55);
        wrw(4'd12, 32'hFFFF);
        rd_lit("unmapped12", 4'd12, 32'd0);
        rd_lit("unmapped15", 4'd15, 32'd0);
        wrb(4'd4, 32'h1234, 4'b0000);
        rd_lit("tick_div_be0", 4'd4, 32'd0);

        // Reset while counting.
        wrw(4'd4, 32'd3);
        wrw(4'd0, 32'h1);
        idle(2);
        do_reset();
        rd_lit("tick_div_rereset", 4'd4, 32'd50000000);
        rd_lit("ctrl_rereset", 4'd0, 32'd0);
        rd_lit("second_rereset", 4'd3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
